rec_play_ctrl: RTL and testbench

Sequences the audio sample memory between the codec's sample handshakes and a single-port synchronous sample RAM.
- Record mode: each ADC sample (sample_end) is written to RAM.
- Play mode: RAM contents are streamed to the DAC path (sample_req).
- Lives in the audio_clk domain between audio_codec and the board-level RAM; replaces the ad-hoc playback/live mux at top level.

---
 rtl/rec_play_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_rec_play_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rec_play_ctrl.sv
// Record/playback sequencer between the codec sample handshakes and a
// single-port synchronous sample RAM (registered read, one cycle latency).
module rec_play_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rec_cmd,
  input  logic              play_cmd,
  input  logic              stop_cmd,
  input  logic              loop_en,
  input  logic              sample_end,
  input  logic              sample_req,
  input  logic [DATA_W-1:0] audio_input,
  output logic [DATA_W-1:0] audio_output,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        state,
  output logic [ADDR_W:0]   rec_len,
  output logic              full
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RECORD   = 2'd1,
    ST_PLAY_PRE = 2'd2,
    ST_PLAY     = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LAST_ADDR = DEPTH_CNT - PTR_ONE;

  state_t              state_reg;
  state_t              state_next;

  logic [ADDR_W:0]     rec_ptr_reg;
  logic [ADDR_W-1:0]   play_ptr_reg;
  logic [ADDR_W:0]     rec_len_reg;
  logic [DATA_W-1:0]   audio_output_reg;
  logic [DATA_W-1:0]   next_sample_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic                mem_we_reg;
  logic [DATA_W-1:0]   mem_wdata_reg;
  logic                full_reg;
  logic                end_reg;
  logic                rd_issue_reg;
  logic                rd_valid_reg;

  // Event strobes decoded from the current state and commands.
  logic                start_rec;
  logic                start_play;
  logic                rec_write;
  logic                rec_full;
  logic                rec_stop;
  logic                play_step;
  logic                play_quit;

  logic [ADDR_W:0]     ptr_inc;
  logic                play_wrap;
  logic [ADDR_W-1:0]   ptr_adv;

  assign ptr_inc   = {1'b0, play_ptr_reg} + PTR_ONE;
  assign play_wrap = (ptr_inc == rec_len_reg);
  assign ptr_adv   = play_wrap ? '0 : ptr_inc[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    start_rec  = 1'b0;
    start_play = 1'b0;
    rec_write  = 1'b0;
    rec_full   = 1'b0;
    rec_stop   = 1'b0;
    play_step  = 1'b0;
    play_quit  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // stop_cmd outranks the start commands even though it does nothing here.
        if (!stop_cmd) begin
          if (rec_cmd) begin
            start_rec  = 1'b1;
            state_next = ST_RECORD;
          end else if (play_cmd && (rec_len_reg != '0)) begin
            start_play = 1'b1;
            state_next = ST_PLAY_PRE;
          end
        end
      end
      ST_RECORD: begin
        if (stop_cmd) begin
          rec_stop   = 1'b1;
          state_next = ST_IDLE;
        end else if (sample_end) begin
          rec_write = 1'b1;
          if (rec_ptr_reg == LAST_ADDR) begin
            rec_full   = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      ST_PLAY_PRE: begin
        if (stop_cmd) begin
          play_quit  = 1'b1;
          state_next = ST_IDLE;
        end else begin
          state_next = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (stop_cmd) begin
          play_quit  = 1'b1;
          state_next = ST_IDLE;
        end else if (sample_req) begin
          if (end_reg) begin
            play_quit  = 1'b1;
            state_next = ST_IDLE;
          end else begin
            play_step = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rec_ptr_reg      <= '0;
      play_ptr_reg     <= '0;
      rec_len_reg      <= '0;
      audio_output_reg <= '0;
      next_sample_reg  <= '0;
      mem_addr_reg     <= '0;
      mem_we_reg       <= 1'b0;
      mem_wdata_reg    <= '0;
      full_reg         <= 1'b0;
      end_reg          <= 1'b0;
      rd_issue_reg     <= 1'b0;
      rd_valid_reg     <= 1'b0;
    end else begin
      mem_we_reg   <= 1'b0;
      full_reg     <= 1'b0;
      // Address registered -> RAM samples it next edge -> data captured one edge later.
      rd_issue_reg <= 1'b0;
      rd_valid_reg <= rd_issue_reg;
      if (rd_valid_reg) begin
        next_sample_reg <= mem_rdata;
      end

      if (start_rec) begin
        rec_ptr_reg <= '0;
      end
      if (rec_write) begin
        mem_we_reg    <= 1'b1;
        mem_addr_reg  <= rec_ptr_reg[ADDR_W-1:0];
        mem_wdata_reg <= audio_input;
        rec_ptr_reg   <= rec_ptr_reg + PTR_ONE;
      end
      if (rec_full) begin
        rec_len_reg <= DEPTH_CNT;
        full_reg    <= 1'b1;
      end
      if (rec_stop) begin
        rec_len_reg <= rec_ptr_reg;
      end

      if (start_play) begin
        play_ptr_reg <= '0;
        mem_addr_reg <= '0;
        rd_issue_reg <= 1'b1;
        end_reg      <= 1'b0;
      end
      if (play_step) begin
        audio_output_reg <= next_sample_reg;
        play_ptr_reg     <= ptr_adv;
        mem_addr_reg     <= ptr_adv;
        rd_issue_reg     <= 1'b1;
        if (play_wrap && !loop_en) begin
          end_reg <= 1'b1;
        end
      end
      if (play_quit) begin
        audio_output_reg <= '0;
        end_reg          <= 1'b0;
        rd_issue_reg     <= 1'b0;
        rd_valid_reg     <= 1'b0;
      end
    end
  end

  assign state        = state_reg;
  assign audio_output = audio_output_reg;
  assign mem_addr     = mem_addr_reg;
  assign mem_we       = mem_we_reg;
  assign mem_wdata    = mem_wdata_reg;
  assign rec_len      = rec_len_reg;
  assign full         = full_reg;

endmodule

// File: tb/tb_rec_play_ctrl.sv
// Bench for rec_play_ctrl (8-entry RAM): directed vector table, randomized
// record/play sessions against a sample-list model, and hand-written corners.
module tb_rec_play_ctrl;
  localparam int AW    = 3;
  localparam int DW    = 16;
  localparam int DEPTH = 8;

  localparam int OP_RESET     = 0;
  localparam int OP_REC       = 1;
  localparam int OP_PLAY      = 2;
  localparam int OP_STOP      = 3;
  localparam int OP_SAMPLE    = 4;
  localparam int OP_REQ       = 5;
  localparam int OP_RECPLAY   = 6;
  localparam int OP_STOPSAMPLE = 7;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rec_cmd = 1'b0;
  logic          play_cmd = 1'b0;
  logic          stop_cmd = 1'b0;
  logic          loop_en = 1'b0;
  logic          sample_end = 1'b0;
  logic          sample_req = 1'b0;
  logic [DW-1:0] audio_input = '0;
  logic [DW-1:0] audio_output;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    state;
  logic [AW:0]   rec_len;
  logic          full;

  rec_play_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .rec_cmd(rec_cmd), .play_cmd(play_cmd),
    .stop_cmd(stop_cmd), .loop_en(loop_en), .sample_end(sample_end),
    .sample_req(sample_req), .audio_input(audio_input),
    .audio_output(audio_output), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .state(state),
    .rec_len(rec_len), .full(full)
  );

  always #5 clk = ~clk;

  // Board RAM: synchronous write, registered read.
  logic [DW-1:0] ram [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) ram[i] = '0;
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int checks = 0;
  int failures = 0;
  int txn = 0;

  logic [1:0]    obs_st_now, obs_st_next, obs_st_late;
  logic [DW-1:0] obs_out, obs_wdata;
  logic [AW:0]   obs_len;
  logic [AW-1:0] obs_addr;
  logic          obs_we, obs_full;
  int            extra_we, extra_full;

  typedef struct {
    int         op;
    logic [15:0] din;
    logic       lp;
    logic [1:0] st_now;
    logic [1:0] st_late;
    logic [15:0] out;
    int         len;
    logic       we;
    int         addr;
    logic       fl;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input int op, input logic [15:0] din, input logic lp,
                              input logic [1:0] st_now, input logic [1:0] st_late,
                              input logic [15:0] out, input int len, input logic we,
                              input int addr, input logic fl);
    vec_t v;
    v.op = op; v.din = din; v.lp = lp; v.st_now = st_now; v.st_late = st_late;
    v.out = out; v.len = len; v.we = we; v.addr = addr; v.fl = fl;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string field, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s txn=%0d actual=%0h required=%0h", field, txn, act, req);
    end
  endtask

  task automatic pulse(input int op, input logic [15:0] din, input logic lp);
    @(negedge clk);
    loop_en = lp;
    audio_input = din;
    case (op)
      OP_RESET:      reset = 1'b1;
      OP_REC:        rec_cmd = 1'b1;
      OP_PLAY:       play_cmd = 1'b1;
      OP_STOP:       stop_cmd = 1'b1;
      OP_SAMPLE:     sample_end = 1'b1;
      OP_REQ:        sample_req = 1'b1;
      OP_RECPLAY:    begin rec_cmd = 1'b1; play_cmd = 1'b1; end
      OP_STOPSAMPLE: begin stop_cmd = 1'b1; sample_end = 1'b1; end
      default: ;
    endcase
    @(posedge clk); #1;
    reset = 1'b0; rec_cmd = 1'b0; play_cmd = 1'b0; stop_cmd = 1'b0;
    sample_end = 1'b0; sample_req = 1'b0;
    obs_st_now = state; obs_out = audio_output; obs_len = rec_len;
    obs_we = mem_we; obs_addr = mem_addr; obs_wdata = mem_wdata; obs_full = full;
    extra_we = 0; extra_full = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (mem_we) extra_we++;
      if (full) extra_full++;
      if (i == 0) obs_st_next = state;
    end
    obs_st_late = state;
    txn++;
    $display("txn %0d op=%0d din=%04h state=%0d->%0d out=%04h rec_len=%0d we=%0b addr=%0d full=%0b",
             txn, op, din, obs_st_now, obs_st_late, obs_out, obs_len, obs_we, obs_addr, obs_full);
  endtask

  task automatic expect_op(input int op, input logic [15:0] din, input logic lp,
                           input logic [1:0] st_now, input logic [1:0] st_late,
                           input logic [15:0] out, input int len, input logic we,
                           input int addr, input logic fl);
    pulse(op, din, lp);
    chk("state_now", 32'(obs_st_now), 32'(st_now));
    chk("state_late", 32'(obs_st_late), 32'(st_late));
    chk("audio_output", 32'(obs_out), 32'(out));
    chk("rec_len", 32'(obs_len), 32'(len));
    chk("mem_we", 32'(obs_we), 32'(we));
    chk("full", 32'(obs_full), 32'(fl));
    chk("extra_we", 32'(extra_we), 32'd0);
    chk("extra_full", 32'(extra_full), 32'd0);
    if (we) begin
      chk("mem_addr", 32'(obs_addr), 32'(addr));
      chk("mem_wdata", 32'(obs_wdata), 32'(din));
    end
    if (op == OP_RESET) chk("reset_addr", 32'(obs_addr), 32'd0);
  endtask

  // Reference model: the recording is just a list of samples plus its length.
  logic [15:0] m_data [DEPTH];
  int          m_len;
  int          n, k, cnt;
  logic        act, lp, ended;
  logic [15:0] d, want;
  logic [15:0] hv [4];
  int          ha [4];

  initial begin
    // Directed vectors: priority, record/stop, play no-loop and loop, overflow, reset mid-play.
    add(OP_RESET, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(OP_PLAY, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(OP_STOP, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(OP_RECPLAY, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) add(OP_SAMPLE, 16'(i), 0, 1, 1, 0, 0, 1, i - 1, 0);
    add(OP_STOP, 0, 0, 0, 0, 0, 4, 0, 0, 0);
    add(OP_PLAY, 0, 0, 2, 3, 0, 4, 0, 0, 0);
    for (int i = 1; i <= 4; i++) add(OP_REQ, 0, 0, 3, 3, 16'(i), 4, 0, 0, 0);
    add(OP_REQ, 0, 0, 0, 0, 0, 4, 0, 0, 0);
    add(OP_REQ, 0, 0, 0, 0, 0, 4, 0, 0, 0);
    add(OP_PLAY, 0, 1, 2, 3, 0, 4, 0, 0, 0);
    for (int i = 0; i < 9; i++) add(OP_REQ, 0, 1, 3, 3, 16'((i % 4) + 1), 4, 0, 0, 0);
    add(OP_STOP, 0, 1, 0, 0, 0, 4, 0, 0, 0);
    add(OP_REC, 0, 0, 1, 1, 0, 4, 0, 0, 0);
    add(OP_SAMPLE, 16'h0A0A, 0, 1, 1, 0, 4, 1, 0, 0);
    add(OP_SAMPLE, 16'h0B0B, 0, 1, 1, 0, 4, 1, 1, 0);
    add(OP_STOPSAMPLE, 16'hDEAD, 0, 0, 0, 0, 2, 0, 0, 0);
    add(OP_REC, 0, 0, 1, 1, 0, 2, 0, 0, 0);
    for (int i = 0; i < 7; i++) add(OP_SAMPLE, 16'((i + 1) * 16'h1100), 0, 1, 1, 0, 2, 1, i, 0);
    add(OP_SAMPLE, 16'h8800, 0, 0, 0, 0, 8, 1, 7, 1);
    add(OP_SAMPLE, 16'h9900, 0, 0, 0, 0, 8, 0, 0, 0);
    add(OP_SAMPLE, 16'hAA00, 0, 0, 0, 0, 8, 0, 0, 0);
    add(OP_PLAY, 0, 0, 2, 3, 0, 8, 0, 0, 0);
    add(OP_REQ, 0, 0, 3, 3, 16'h1100, 8, 0, 0, 0);
    add(OP_RESET, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    for (int i = 0; i < vecs.size(); i++)
      expect_op(vecs[i].op, vecs[i].din, vecs[i].lp, vecs[i].st_now, vecs[i].st_late,
                vecs[i].out, vecs[i].len, vecs[i].we, vecs[i].addr, vecs[i].fl);

    // Randomized sessions; the last vector left the block reset with nothing recorded.
    m_len = 0;
    for (int s = 0; s < 25; s++) begin
      if ($urandom_range(0, 1) == 0) begin
        n = $urandom_range(0, 10);
        cnt = 0;
        act = 1'b1;
        expect_op(OP_REC, 0, 0, 1, 1, 0, m_len, 0, 0, 0);
        for (int j = 0; j < n; j++) begin
          d = 16'($urandom);
          if (act) begin
            m_data[cnt] = d;
            cnt++;
            if (cnt == DEPTH) begin
              act = 1'b0;
              m_len = DEPTH;
              expect_op(OP_SAMPLE, d, 0, 0, 0, 0, m_len, 1, cnt - 1, 1);
            end else begin
              expect_op(OP_SAMPLE, d, 0, 1, 1, 0, m_len, 1, cnt - 1, 0);
            end
          end else begin
            expect_op(OP_SAMPLE, d, 0, 0, 0, 0, m_len, 0, 0, 0);
          end
        end
        if (act) m_len = cnt;
        expect_op(OP_STOP, 0, 0, 0, 0, 0, m_len, 0, 0, 0);
      end else begin
        lp = 1'($urandom_range(0, 1));
        k = $urandom_range(1, 12);
        if (m_len == 0) expect_op(OP_PLAY, 0, lp, 0, 0, 0, 0, 0, 0, 0);
        else            expect_op(OP_PLAY, 0, lp, 2, 3, 0, m_len, 0, 0, 0);
        ended = (m_len == 0);
        for (int j = 0; j < k; j++) begin
          if (ended) begin
            expect_op(OP_REQ, 0, lp, 0, 0, 0, m_len, 0, 0, 0);
          end else if (lp) begin
            want = m_data[j % m_len];
            expect_op(OP_REQ, 0, lp, 3, 3, want, m_len, 0, 0, 0);
          end else if (j < m_len) begin
            want = m_data[j];
            expect_op(OP_REQ, 0, lp, 3, 3, want, m_len, 0, 0, 0);
          end else begin
            ended = 1'b1;
            expect_op(OP_REQ, 0, lp, 0, 0, 0, m_len, 0, 0, 0);
          end
        end
        expect_op(OP_STOP, 0, lp, 0, 0, 0, m_len, 0, 0, 0);
      end
    end

    // PLAY_PRE lasts exactly one cycle; read address advances and wraps to 0.
    expect_op(OP_RESET, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    expect_op(OP_REC, 0, 1, 1, 1, 0, 0, 0, 0, 0);
    expect_op(OP_SAMPLE, 16'h0111, 1, 1, 1, 0, 0, 1, 0, 0);
    expect_op(OP_SAMPLE, 16'h0222, 1, 1, 1, 0, 0, 1, 1, 0);
    expect_op(OP_SAMPLE, 16'h0333, 1, 1, 1, 0, 0, 1, 2, 0);
    expect_op(OP_STOP, 0, 1, 0, 0, 0, 3, 0, 0, 0);
    expect_op(OP_PLAY, 0, 1, 2, 3, 0, 3, 0, 0, 0);
    chk("pre_one_cycle", 32'(obs_st_next), 32'd3);
    chk("pre_addr", 32'(obs_addr), 32'd0);
    hv[0] = 16'h0111; hv[1] = 16'h0222; hv[2] = 16'h0333; hv[3] = 16'h0111;
    ha[0] = 1; ha[1] = 2; ha[2] = 0; ha[3] = 1;
    for (int i = 0; i < 4; i++) begin
      expect_op(OP_REQ, 0, 1, 3, 3, hv[i], 3, 0, 0, 0);
      chk("play_addr", 32'(obs_addr), 32'(ha[i]));
    end
    expect_op(OP_STOP, 0, 1, 0, 0, 0, 3, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout txn=%0d", txn);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule
